// File: rtl/rf_scoreboard_if.sv
// Register-file scoreboard bus: source reads, issue request/stall, writeback and status.
// The master is the ID/WB pipeline side; the slave is the scoreboard itself.
interface rf_scoreboard_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 2
);
  localparam int unsigned NUM_REGS = 2**REG_AW;

  logic [REG_AW-1:0]   rd_addr0;
  logic [REG_AW-1:0]   rd_addr1;
  logic                rd_use0;
  logic                rd_use1;
  logic [DATA_W-1:0]   rd_data0;
  logic [DATA_W-1:0]   rd_data1;
  logic                iss_valid;
  logic                iss_wen;
  logic [REG_AW-1:0]   iss_dst;
  logic                stall;
  logic                wb_valid;
  logic [REG_AW-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic [NUM_REGS-1:0] busy_vec;
  logic                sb_err;

  modport master (
    output rd_addr0, rd_addr1, rd_use0, rd_use1,
    output iss_valid, iss_wen, iss_dst,
    output wb_valid, wb_addr, wb_data,
    input  rd_data0, rd_data1, stall, busy_vec, sb_err
  );

  modport slave (
    input  rd_addr0, rd_addr1, rd_use0, rd_use1,
    input  iss_valid, iss_wen, iss_dst,
    input  wb_valid, wb_addr, wb_data,
    output rd_data0, rd_data1, stall, busy_vec, sb_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Register file with per-register pending-write counters: bypassed reads, issue
// stall on RAW hazards or counter saturation, and a sticky underflow flag.
module rf_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 2,
  parameter int unsigned PEND_W = 2
) (
  input logic            clk,
  input logic            resetn,
  rf_scoreboard_if.slave sb
);
  localparam int unsigned NUM_REGS = 2**REG_AW;
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [PEND_W-1:0]   cnt_q  [NUM_REGS];
  logic                sb_err_q;

  logic                hit0_c, hit1_c, hit_dst_c;
  logic                busy0_c, busy1_c, dst_sat_c;
  logic                stall_c, accept_c;
  logic [NUM_REGS-1:0] inc_c, dec_c, under_c;

  // Writeback-address matches against the three register ports
  always_comb begin
    hit0_c    = sb.wb_valid && (sb.wb_addr == sb.rd_addr0);
    hit1_c    = sb.wb_valid && (sb.wb_addr == sb.rd_addr1);
    hit_dst_c = sb.wb_valid && (sb.wb_addr == sb.iss_dst);
  end

  // Write-through reads
  always_comb begin
    sb.rd_data0 = hit0_c ? sb.wb_data : regs_q[sb.rd_addr0];
    sb.rd_data1 = hit1_c ? sb.wb_data : regs_q[sb.rd_addr1];
  end

  // A source whose last pending write retires this cycle is no longer busy
  always_comb begin
    busy0_c   = (cnt_q[sb.rd_addr0] != '0) &&
                !(hit0_c && (cnt_q[sb.rd_addr0] == PEND_W'(1)));
    busy1_c   = (cnt_q[sb.rd_addr1] != '0) &&
                !(hit1_c && (cnt_q[sb.rd_addr1] == PEND_W'(1)));
    dst_sat_c = sb.iss_wen && (cnt_q[sb.iss_dst] == PMAX) && !hit_dst_c;
    stall_c   = resetn && sb.iss_valid &&
                ((sb.rd_use0 && busy0_c) || (sb.rd_use1 && busy1_c) || dst_sat_c);
    accept_c  = resetn && sb.iss_valid && !stall_c;
  end

  assign sb.stall  = stall_c;
  assign sb.sb_err = sb_err_q;

  // Per-register increment/decrement requests and underflow detection
  always_comb begin
    inc_c   = '0;
    dec_c   = '0;
    under_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      inc_c[i]   = accept_c && sb.iss_wen && (sb.iss_dst == REG_AW'(i));
      dec_c[i]   = sb.wb_valid && (sb.wb_addr == REG_AW'(i));
      under_c[i] = dec_c[i] && !inc_c[i] && (cnt_q[i] == '0);
    end
  end

  always_comb begin
    sb.busy_vec = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      sb.busy_vec[i] = (cnt_q[i] != '0);
    end
  end

  // Pending counters: simultaneous inc and dec cancel; decrement clamps at zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (inc_c[i] && !dec_c[i]) begin
          cnt_q[i] <= cnt_q[i] + PEND_W'(1);
        end else if (dec_c[i] && !inc_c[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - PEND_W'(1);
        end
      end
      if (|under_c) begin
        sb_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (sb.wb_valid) begin
      regs_q[sb.wb_addr] <= sb.wb_data;
    end
  end

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The module SHALL have parameter REG_AW, default 2, register address width; NUM_REGS = 2**REG_AW.
REQ-003 The module SHALL have parameter PEND_W, default 2, width of each per-register pending-write counter; max count PMAX = 2**PEND_W-1.
REQ-004 Ports SHALL be as follows:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- rd_addr0, rd_addr1  in  REG_AW  source register addresses
- rd_use0, rd_use1  in  1  source operand actually used by the ID-stage instruction
- rd_data0, rd_data1  out  DATA_W  source operand values
- iss_valid  in  1  ID-stage instruction presented for issue
- iss_wen  in  1  issuing instruction writes a destination
- iss_dst  in  REG_AW  destination register
- stall  out  1  issue blocked this cycle
- wb_valid  in  1  writeback strobe
- wb_addr  in  REG_AW  writeback register
- wb_data  in  DATA_W  writeback value
- busy_vec  out  NUM_REGS  bit i = register i has pending count != 0
- sb_err  out  1  sticky scoreboard underflow flag

Function
REQ-005 Storage SHALL be NUM_REGS x DATA_W registers plus NUM_REGS x PEND_W pending counters.
REQ-006 Reads SHALL be combinational; rd_dataN = wb_data when wb_valid and wb_addr == rd_addrN (write-through bypass), else stored value.
REQ-007 On a rising edge with wb_valid, register wb_addr SHALL take wb_data.
REQ-008 Effective busy for source N: count[rd_addrN] != 0, except not busy when count == 1 and wb_valid and wb_addr == rd_addrN (same-cycle clear).
REQ-009 stall SHALL be combinational = iss_valid AND (src0 hazard OR src1 hazard OR dst saturation).
REQ-010 srcN hazard = rd_useN AND effective busy of rd_addrN.
REQ-011 Dst saturation = iss_wen AND count[iss_dst] == PMAX AND NOT (wb_valid AND wb_addr == iss_dst).
REQ-012 Issue SHALL be accepted when iss_valid AND NOT stall; stall SHALL be 0 when iss_valid is 0.
REQ-013 Counter update per edge: inc = accepted issue with iss_wen to register r; dec = wb_valid to r.
REQ-014 inc only: count[r] +1; dec only: count[r] -1; both: unchanged; neither: unchanged.
REQ-015 dec with count[r] == 0 and no inc to r: count SHALL stay 0, sb_err SHALL set and hold until reset; data write still occurs.
REQ-016 Counter SHALL never wrap past PMAX (guaranteed by REQ-011) or below 0 (REQ-015).
REQ-017 busy_vec SHALL reflect registered counts (pre-edge state), without the REQ-008 bypass.
REQ-018 Issue and writeback to different registers in the same cycle SHALL update independently.
REQ-019 A stalled issue SHALL change no state; the caller holds its inputs.

Reset
REQ-020 While resetn low: all data registers 0, all counters 0, sb_err 0, hence busy_vec 0; stall = 0 regardless of other inputs.
REQ-021 Reset asserted mid-operation SHALL discard all pending counts immediately; writebacks arriving after release SHALL set sb_err per REQ-015.
REQ-022 First rising edge after resetn rises SHALL behave as a normal cycle.

Verification
REQ-023 Reset, then wb_valid=1 wb_addr=1 wb_data=0x1234 with rd_addr0=1 -> rd_data0=0x1234 same cycle; after edge, stored R1=0x1234; sb_err=1 (count was 0).
REQ-024 Issue iss_wen=1 iss_dst=2; next cycle iss_valid with rd_use0=1 rd_addr0=2 -> stall=1, busy_vec=0100; cycle with wb_valid wb_addr=2 wb_data=7 -> stall=0, rd_data0=7, issue accepted.
REQ-025 PEND_W=2: three accepted issues to R3 -> count 3; fourth issue to R3 -> stall=1; same cycle with wb to R3 -> stall=0, count stays 3.
REQ-026 Same-cycle accepted issue to R0 and wb to R1 with counts R0=0, R1=1 -> next cycle busy_vec=0001.
REQ-027 rd_use0=0 with rd_addr0 busy, iss_wen=0 -> stall=0; iss_valid=0 with any hazard -> stall=0.
REQ-028 Two pending writes to R1, assert resetn=0 for one cycle -> busy_vec=0, data 0, sb_err 0; subsequent wb to R1 -> sb_err=1.
